toggle_checker: RTL and testbench

Receive-side monitor for the toggle generator's output. It samples a single toggling signal in the same clock domain and checks that edges arrive exactly every HALF_PERIOD cycles. It locks after a run of correct edges and flags any missing or early edge once locked. It sits beside the toggle generator in `tb_top` and in any integration that consumes the toggle output, and reports lock, a sticky error, and saturating edge/error counters.

---
 rtl/toggle_checker_if.sv | 22 ++
 rtl/toggle_checker.sv | 123 ++++++++++++
 tb/tb_toggle_checker.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_checker_if.sv
// Status and stimulus bundle for toggle_checker: the monitored toggle line plus
// the lock/error/counter observation signals.
interface toggle_checker_if #(
  parameter int CNT_W = 16
);
  logic             toggle_in;
  logic             locked;
  logic             error;
  logic [1:0]       state;
  logic [CNT_W-1:0] edge_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output toggle_in,
    input  locked, error, state, edge_count, err_count
  );

  modport slave (
    input  toggle_in,
    output locked, error, state, edge_count, err_count
  );
endinterface

// File: rtl/toggle_checker.sv
// Checks that toggle_in changes exactly every HALF_PERIOD cycles; locks after
// LOCK_COUNT good edges. Optional macro TOGGLE_CHECKER_RELOCK_EN lets FAULT relock.
module toggle_checker #(
  parameter int HALF_PERIOD = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  toggle_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int GAP_W  = $clog2(HALF_PERIOD + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(HALF_PERIOD);
  localparam logic [GAP_W:0]    HP_IVL    = (GAP_W + 1)'(HALF_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_q;
  logic                in_q;
  logic [GAP_W-1:0]    gap_q;
  logic [GOOD_W-1:0]   good_cnt_q;
  logic                locked_q;
  logic                error_q;
  logic [CNT_W-1:0]    edge_cnt_q;
  logic [CNT_W-1:0]    err_cnt_q;

  logic                edge_det;
  logic [GAP_W:0]      interval;
  logic                due;
  logic                good;
  logic                early;
  logic                missing;
  logic                bad;

  // interval is the edge spacing if an edge lands this cycle; gap saturates so
  // a long silence is flagged as missing exactly once.
  assign edge_det = bus.toggle_in ^ in_q;
  assign interval = {1'b0, gap_q} + (GAP_W + 1)'(1);
  assign due      = (interval == HP_IVL);
  assign good     = edge_det & due;
  assign early    = edge_det & (interval < HP_IVL);
  assign missing  = ~edge_det & due & (state_q != IDLE);
  assign bad      = early | missing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_q       <= 1'b0;
      gap_q      <= '0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      edge_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      in_q <= bus.toggle_in;

      if (edge_det) begin
        gap_q      <= '0;
        edge_cnt_q <= sat_inc(edge_cnt_q);
      end else if (gap_q != GAP_MAX) begin
        gap_q <= gap_q + GAP_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_q    <= SYNC;
            good_cnt_q <= '0;
          end
        end
        SYNC: begin
          if (bad) begin
            good_cnt_q <= '0;
          end else if (good) begin
            good_cnt_q <= good_cnt_q + GOOD_W'(1);
            if (good_cnt_q == GOOD_LAST) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (bad) begin
            state_q   <= FAULT;
            locked_q  <= 1'b0;
            error_q   <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
          end
        end
        FAULT: begin
`ifdef TOGGLE_CHECKER_RELOCK_EN
          if (edge_det) begin
            state_q    <= SYNC;
            good_cnt_q <= '0;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.locked     = locked_q;
  assign bus.error      = error_q;
  assign bus.state      = state_q;
  assign bus.edge_count = edge_cnt_q;
  assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_toggle_checker.sv
// Bench for toggle_checker: three instances (HALF_PERIOD 1/3, CNT_W 16/2) driven
// by directed scenarios and random stimulus against an edge-timestamp model.
`timescale 1ns/1ps
module tb_toggle_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toggle_checker_if #(.CNT_W(16)) if1 ();
  toggle_checker_if #(.CNT_W(16)) if3 ();
  toggle_checker_if #(.CNT_W(2))  ifc ();

  toggle_checker #(.HALF_PERIOD(1), .LOCK_COUNT(4), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  toggle_checker #(.HALF_PERIOD(3), .LOCK_COUNT(4), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));
  toggle_checker #(.HALF_PERIOD(1), .LOCK_COUNT(4), .CNT_W(2)) dutc (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  // Per-instance views so loops can walk all three checkers.
  logic [1:0]  o_st [3];
  logic        o_lk [3];
  logic        o_er [3];
  logic [15:0] o_ec [3];
  logic [15:0] o_xc [3];
  assign o_st[0] = if1.state;  assign o_lk[0] = if1.locked;  assign o_er[0] = if1.error;
  assign o_ec[0] = if1.edge_count; assign o_xc[0] = if1.err_count;
  assign o_st[1] = if3.state;  assign o_lk[1] = if3.locked;  assign o_er[1] = if3.error;
  assign o_ec[1] = if3.edge_count; assign o_xc[1] = if3.err_count;
  assign o_st[2] = ifc.state;  assign o_lk[2] = ifc.locked;  assign o_er[2] = ifc.error;
  assign o_ec[2] = {14'd0, ifc.edge_count}; assign o_xc[2] = {14'd0, ifc.err_count};

  int hp   [3] = '{1, 3, 1};
  int emax [3] = '{65535, 65535, 3};
  localparam int LOCK_N = 4;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit tv [3] = '{1'b0, 1'b0, 1'b0};

  // Reference model: timestamps of the last edge, phases 0..3 as in the debug encoding.
  int m_st [3];
  int m_gc [3];
  int m_ec [3];
  int m_xc [3];
  int m_last [3];
  bit m_in [3];
  bit m_err [3];

  task automatic model_reset(input int k);
    m_st[k] = 0; m_gc[k] = 0; m_ec[k] = 0; m_xc[k] = 0;
    m_last[k] = 0; m_in[k] = 1'b0; m_err[k] = 1'b0;
  endtask

  task automatic model_step(input int k, input bit t);
    bit e, good, early, miss, bad;
    int iv;
    e     = t ^ m_in[k];
    iv    = cyc - m_last[k];
    good  = e && (iv == hp[k]);
    early = e && (iv < hp[k]);
    miss  = !e && (m_st[k] != 0) && (iv == hp[k]);
    bad   = early || miss;
    if (e && m_ec[k] < emax[k]) m_ec[k]++;
    case (m_st[k])
      0: if (e) begin m_st[k] = 1; m_gc[k] = 0; end
      1: begin
        if (bad) m_gc[k] = 0;
        else if (good) begin
          m_gc[k]++;
          if (m_gc[k] == LOCK_N) m_st[k] = 2;
        end
      end
      2: if (bad) begin
        m_st[k] = 3; m_err[k] = 1'b1;
        if (m_xc[k] < emax[k]) m_xc[k]++;
      end
      default: begin
`ifdef TOGGLE_CHECKER_RELOCK_EN
        if (e) begin m_st[k] = 1; m_gc[k] = 0; end
`endif
      end
    endcase
    m_in[k] = t;
    if (e) m_last[k] = cyc;
  endtask

  // One clock: apply tv, advance the model at the edge, return 1ns after it.
  task automatic step();
    if1.toggle_in = tv[0];
    if3.toggle_in = tv[1];
    ifc.toggle_in = tv[2];
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) model_reset(k);
      else model_step(k, tv[k]);
    end
    #1;
  endtask

  task automatic do_reset();
    tv = '{1'b0, 1'b0, 1'b0};
    if1.toggle_in = 1'b0; if3.toggle_in = 1'b0; ifc.toggle_in = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) model_reset(k);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if1.toggle_in = 1'b0; if3.toggle_in = 1'b0; ifc.toggle_in = 1'b0;
    for (int k = 0; k < 3; k++) model_reset(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (o_st[k] !== 2'd0 || o_lk[k] !== 1'b0 || o_er[k] !== 1'b0 ||
          o_ec[k] !== 16'd0 || o_xc[k] !== 16'd0) begin
        n_bad++;
        $display("FAIL reset dut%0d: got st=%0d lk=%0b er=%0b ec=%0d xc=%0d, want all 0",
                 k, o_st[k], o_lk[k], o_er[k], o_ec[k], o_xc[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tv[0] = ~tv[0];
      step();
      if (i == 4) begin
        n_cmp++;
        if (if1.locked !== 1'b0) begin
          n_bad++; $display("FAIL lock_early: got locked=%0b want 0 after 4 edges", if1.locked);
        end
      end
    end
    n_cmp++;
    if (if1.locked !== 1'b1 || if1.state !== 2'd2) begin
      n_bad++; $display("FAIL lock_locked: got locked=%0b state=%0d want 1/2", if1.locked, if1.state);
    end
    n_cmp++;
    if (if1.edge_count !== 16'd5 || if1.error !== 1'b0) begin
      n_bad++; $display("FAIL lock_counts: got edge_count=%0d error=%0b want 5/0", if1.edge_count, if1.error);
    end
  endtask

  task automatic test_missing_fault();
    step();
    n_cmp++;
    if (if1.state !== 2'd3 || if1.locked !== 1'b0) begin
      n_bad++; $display("FAIL miss_state: got state=%0d locked=%0b want 3/0", if1.state, if1.locked);
    end
    n_cmp++;
    if (if1.error !== 1'b1 || if1.err_count !== 16'd1) begin
      n_bad++; $display("FAIL miss_err: got error=%0b err_count=%0d want 1/1", if1.error, if1.err_count);
    end
  endtask

  task automatic test_after_fault();
    for (int i = 1; i <= 10; i++) begin
      tv[0] = ~tv[0];
      step();
`ifdef TOGGLE_CHECKER_RELOCK_EN
      if (i == 4 || i == 5) begin
        n_cmp++;
        if (if1.locked !== (i == 5)) begin
          n_bad++; $display("FAIL relock_time: edge %0d got locked=%0b want %0b", i, if1.locked, i == 5);
        end
      end
`endif
    end
`ifdef TOGGLE_CHECKER_RELOCK_EN
    n_cmp++;
    if (if1.state !== 2'd2 || if1.locked !== 1'b1) begin
      n_bad++; $display("FAIL relock_state: got state=%0d locked=%0b want 2/1", if1.state, if1.locked);
    end
`else
    n_cmp++;
    if (if1.state !== 2'd3 || if1.locked !== 1'b0) begin
      n_bad++; $display("FAIL terminal_state: got state=%0d locked=%0b want 3/0", if1.state, if1.locked);
    end
`endif
    n_cmp++;
    if (if1.err_count !== 16'd1 || if1.error !== 1'b1) begin
      n_bad++; $display("FAIL post_fault_err: got err_count=%0d error=%0b want 1/1", if1.err_count, if1.error);
    end
  endtask

  task automatic lock_hp3();
    do_reset();
    tv[1] = ~tv[1];
    step();
    for (int i = 0; i < 4; i++) begin
      step(); step();
      tv[1] = ~tv[1];
      step();
    end
    n_cmp++;
    if (if3.locked !== 1'b1) begin
      n_bad++; $display("FAIL hp3_lock: got locked=%0b want 1", if3.locked);
    end
  endtask

  task automatic test_early_hp3();
    lock_hp3();
    step();
    tv[1] = ~tv[1];
    step();
    n_cmp++;
    if (if3.state !== 2'd3 || if3.err_count !== 16'd1 || if3.error !== 1'b1) begin
      n_bad++; $display("FAIL hp3_early: got state=%0d err_count=%0d error=%0b want 3/1/1",
                        if3.state, if3.err_count, if3.error);
    end
  endtask

  task automatic test_missing_hp3();
    lock_hp3();
    step(); step();
    n_cmp++;
    if (if3.state !== 2'd2) begin
      n_bad++; $display("FAIL hp3_miss_soon: got state=%0d want 2 two cycles after edge", if3.state);
    end
    step();
    n_cmp++;
    if (if3.state !== 2'd3 || if3.err_count !== 16'd1) begin
      n_bad++; $display("FAIL hp3_miss: got state=%0d err_count=%0d want 3/1", if3.state, if3.err_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tv[0] = ~tv[0];
      step();
    end
    n_cmp++;
    if (if1.locked !== 1'b1) begin
      n_bad++; $display("FAIL arst_prelock: got locked=%0b want 1", if1.locked);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if1.state !== 2'd0 || if1.locked !== 1'b0 || if1.error !== 1'b0 ||
        if1.edge_count !== 16'd0 || if1.err_count !== 16'd0) begin
      n_bad++; $display("FAIL arst_clear: got st=%0d lk=%0b er=%0b ec=%0d xc=%0d want all 0",
                        if1.state, if1.locked, if1.error, if1.edge_count, if1.err_count);
    end
    for (int k = 0; k < 3; k++) model_reset(k);
    rst_n = 1'b1;
    // toggle_in is still high, so the first clock after release is an edge.
    step();
    n_cmp++;
    if (if1.state !== 2'd1 || if1.edge_count !== 16'd1) begin
      n_bad++; $display("FAIL arst_restart: got state=%0d edge_count=%0d want 1/1", if1.state, if1.edge_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      tv[2] = ~tv[2];
      step();
      n_cmp++;
      if (ifc.edge_count !== 2'((i > 3) ? 3 : i)) begin
        n_bad++; $display("FAIL sat_edges: edge %0d got edge_count=%0d want %0d", i, ifc.edge_count, (i > 3) ? 3 : i);
      end
    end
  endtask

  task automatic test_random();
    int since3;
    do_reset();
    since3 = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        do_reset();
        since3 = 0;
      end
      if ($urandom_range(99) < 90) tv[0] = ~tv[0];
      if ($urandom_range(99) < 90) tv[2] = ~tv[2];
      since3++;
      if ((since3 >= 3 && $urandom_range(99) < 92) || $urandom_range(99) < 3) begin
        tv[1] = ~tv[1];
        since3 = 0;
      end
      step();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (o_st[k] !== 2'(m_st[k]) || o_lk[k] !== (m_st[k] == 2) || o_er[k] !== m_err[k] ||
            o_ec[k] !== 16'(m_ec[k]) || o_xc[k] !== 16'(m_xc[k])) begin
          n_bad++;
          $display("FAIL rand dut%0d cyc %0d: got st=%0d lk=%0b er=%0b ec=%0d xc=%0d want st=%0d lk=%0b er=%0b ec=%0d xc=%0d",
                   k, cyc, o_st[k], o_lk[k], o_er[k], o_ec[k], o_xc[k],
                   m_st[k], m_st[k] == 2, m_err[k], m_ec[k], m_xc[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_missing_fault();
    test_after_fault();
    test_early_hp3();
    test_missing_hp3();
    test_async_reset();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
